scrypt_multi_dispatch: RTL and testbench
========================================

Name: scrypt_multi_dispatch

Overview:
- Front-end that shares one 640-bit block-header stream across NUM_CORES scrypt_ipcore instances.
- Assigns jobs in strict round-robin order, captures each core's 256-bit hash, and retires results in submission order with a sequence tag.
- Sits between the header source and the core array; the single-core harness becomes one channel of this block.

Parameters:
- WIDTH_IN, 640: block header width.
- WIDTH_OUT, 256: scrypt hash width.
- NUM_CORES, 4: number of attached cores; legal range 1..16.
- SEQ_W, 32: width of the job sequence tag.
- PTR_W, $clog2(NUM_CORES) min 1: width of the round-robin pointers.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous, active-low reset
- in_valid  in  1  header offered
- in_ready  out  1  header accepted when in_valid && in_ready
- in_header  in  WIDTH_IN  block header
- core_header  out  WIDTH_IN  registered header bus shared by all cores
- core_valid_in  out  NUM_CORES  one-hot, one-cycle start pulse per core
- core_ready  in  NUM_CORES  per-core scrypt_ready
- core_out_ready  out  NUM_CORES  per-core out_ready, tied high after reset
- core_valid_out  in  NUM_CORES  per-core result strobe
- core_out  in  NUM_CORES*WIDTH_OUT  concatenated hashes; core k at [k*WIDTH_OUT +: WIDTH_OUT]
- out_valid  out  1  result available
- out_ready  in  1  downstream accepts
- out_hash  out  WIDTH_OUT  retired hash
- out_seq  out  SEQ_W  sequence tag of the retired job
- in_flight  out  PTR_W+1  busy core count
- err_stray  out  1  sticky: strobe from a core that is not busy

Behaviour:
- Reset: all outputs 0, except core_out_ready=0 during reset and all-1 afterwards. Pointers d_ptr and r_ptr = 0. seq=0. busy, done and tag arrays cleared.
- Reset mid-operation: everything above is cleared. In-flight jobs are abandoned, because the cores share rst_n. No result from before reset may appear on out_*.
- in_ready = !busy[d_ptr] && core_ready[d_ptr] && !reset. It is combinational from registered state only.
- Accept at edge T:
  - core_header <= in_header; core_valid_in <= onehot(d_ptr) for exactly one cycle.
  - busy[d_ptr] <= 1; tag[d_ptr] <= seq; seq <= seq+1, wrapping mod 2^SEQ_W.
  - d_ptr <= d_ptr+1, wrapping at NUM_CORES-1 to 0.
- Capture: core_valid_out[k] && busy[k] && !done[k] at edge E gives res[k] <= core_out slice k and done[k] <= 1.
  - Strobe on a core with !busy[k] or done[k]: data ignored, err_stray <= 1, held until reset.
- Retire: done[r_ptr] && (!out_valid || out_ready) at edge E gives:
  - out_hash <= res[r_ptr]; out_seq <= tag[r_ptr]; out_valid <= 1.
  - busy[r_ptr], done[r_ptr] <= 0; r_ptr <= r_ptr+1, wrapping.
- out_valid && out_ready with no retire that edge: out_valid <= 0. out_* hold stable while out_valid && !out_ready.
- Minimum latency from core strobe to out_valid: 2 edges (capture, then retire).
- Ordering: outputs appear strictly in accept order, even when later cores finish first. Finished results wait in res[].
- Same-core free and re-dispatch: a core freed by retire at edge E becomes dispatchable from cycle E+1, never in the same cycle.
- Full: all busy gives in_ready=0.
- Empty: in_flight=0 and out_valid stays 0.
- in_flight = popcount(busy). Accept and retire on the same edge leave it unchanged.
- NUM_CORES=1: pointers stay 0 and the block degenerates to a single-job pass-through with tagging.

Decomposition:
- Package scrypt_pkg holds WIDTH_IN and WIDTH_OUT defaults and the header_t / hash_t typedefs shared with scrypt_ipcore and benches.
- One sub-module, scrypt_rr_ptr: modulo-NUM_CORES wrapping pointer with an increment enable. It is instantiated twice, for d_ptr and r_ptr.
- The capture/retire logic stays in the top module.

Test Plan:
- Single job, NUM_CORES=4, all cores ready: header H0 accepted at T → core_valid_in=4'b0001 at T+1. Core 0 strobes hash X at E → out_valid at E+2 with out_hash=X, out_seq=0.
- Out-of-order completion: accept H0..H3; cores finish in order 3,1,0,2 → out_seq 0,1,2,3 in order, each out_hash matching its own core. in_flight goes 4→0.
- Full/back-pressure: 5 headers offered with no results → in_ready=0 after the 4th. The 5th is accepted only on the cycle after seq 0 retires, and goes to core 0 with seq=4.
- Output stall: hold out_ready=0 while cores 0 and 1 finish → out_hash/out_seq (0) stay stable. Core 1 is not retired. On out_ready=1 they retire on consecutive cycles.
- Stray strobe: core_valid_out[2] pulsed with no job → err_stray=1, out_valid stays 0. A later normal job still completes correctly.
- Reset mid-run: 3 jobs in flight, rst_n low for one edge → all outputs 0, seq restarts at 0, and no stale result is ever emitted.

Source files
------------

// File: rtl/scrypt_pkg.sv
// Shared scrypt widths and bus typedefs for the core array, the dispatcher and the benches.
package scrypt_pkg;

  localparam int HDR_W  = 640;
  localparam int HASH_W = 256;

  typedef logic [HDR_W-1:0]  header_t;
  typedef logic [HASH_W-1:0] hash_t;

endpackage

// File: rtl/scrypt_rr_ptr.sv
// Modulo-N round-robin pointer; advances by one on inc, wraps from N-1 to 0, clears on reset.
module scrypt_rr_ptr #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] ptr
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= (ptr == W'(N - 1)) ? '0 : ptr + W'(1);
    end
  end

endmodule

// File: rtl/scrypt_multi_dispatch.sv
// Round-robin header dispatch to NUM_CORES scrypt cores with in-order, tagged retirement.
// Strobe-to-out_valid is two edges; in_ready drops while the next core is busy or not ready.
module scrypt_multi_dispatch
  import scrypt_pkg::*;
#(
  parameter int WIDTH_IN  = HDR_W,
  parameter int WIDTH_OUT = HASH_W,
  parameter int NUM_CORES = 4,
  parameter int SEQ_W     = 32,
  parameter int PTR_W     = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [WIDTH_IN-1:0]            in_header,
  output logic [WIDTH_IN-1:0]            core_header,
  output logic [NUM_CORES-1:0]           core_valid_in,
  input  logic [NUM_CORES-1:0]           core_ready,
  output logic [NUM_CORES-1:0]           core_out_ready,
  input  logic [NUM_CORES-1:0]           core_valid_out,
  input  logic [NUM_CORES*WIDTH_OUT-1:0] core_out,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [WIDTH_OUT-1:0]           out_hash,
  output logic [SEQ_W-1:0]               out_seq,
  output logic [PTR_W:0]                 in_flight,
  output logic                           err_stray
);

  logic [NUM_CORES-1:0] busy;
  logic [NUM_CORES-1:0] done;
  logic [WIDTH_OUT-1:0] res [NUM_CORES];
  logic [SEQ_W-1:0]     tag [NUM_CORES];
  logic [SEQ_W-1:0]     seq;
  logic [PTR_W-1:0]     d_ptr;
  logic [PTR_W-1:0]     r_ptr;
  logic                 accept;
  logic                 retire;

  assign in_ready = rst_n && !busy[d_ptr] && core_ready[d_ptr];
  assign accept   = in_valid && in_ready;
  assign retire   = done[r_ptr] && (!out_valid || out_ready);

  scrypt_rr_ptr #(.N(NUM_CORES), .W(PTR_W)) u_d_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (accept),
    .ptr   (d_ptr)
  );

  scrypt_rr_ptr #(.N(NUM_CORES), .W(PTR_W)) u_r_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (retire),
    .ptr   (r_ptr)
  );

  always_comb begin
    in_flight = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      in_flight = in_flight + (PTR_W + 1)'(busy[k]);
    end
  end

  // Accept only targets an idle core and retire only a done one, so the bit updates never collide.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy           <= '0;
      done           <= '0;
      seq            <= '0;
      core_header    <= '0;
      core_valid_in  <= '0;
      core_out_ready <= '0;
      out_valid      <= 1'b0;
      out_hash       <= '0;
      out_seq        <= '0;
      err_stray      <= 1'b0;
    end else begin
      core_out_ready <= '1;
      core_valid_in  <= '0;
      if (accept) begin
        core_header    <= in_header;
        core_valid_in  <= NUM_CORES'(1) << d_ptr;
        busy[d_ptr]    <= 1'b1;
        seq            <= seq + SEQ_W'(1);
      end
      for (int k = 0; k < NUM_CORES; k++) begin
        if (core_valid_out[k]) begin
          if (busy[k] && !done[k]) begin
            done[k] <= 1'b1;
          end else begin
            err_stray <= 1'b1;
          end
        end
      end
      if (retire) begin
        out_hash    <= res[r_ptr];
        out_seq     <= tag[r_ptr];
        out_valid   <= 1'b1;
        busy[r_ptr] <= 1'b0;
        done[r_ptr] <= 1'b0;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_CORES; k++) begin
        res[k] <= '0;
        tag[k] <= '0;
      end
    end else begin
      if (accept) begin
        tag[d_ptr] <= seq;
      end
      for (int k = 0; k < NUM_CORES; k++) begin
        if (core_valid_out[k] && busy[k] && !done[k]) begin
          res[k] <= core_out[k*WIDTH_OUT +: WIDTH_OUT];
        end
      end
    end
  end

endmodule

// File: tb/tb_scrypt_multi_dispatch.sv
// Directed bench for scrypt_multi_dispatch with four modelled cores driven straight from the stimulus.
module tb_scrypt_multi_dispatch;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [639:0]  in_header;
  logic [639:0]  core_header;
  logic [3:0]    core_valid_in;
  logic [3:0]    core_ready;
  logic [3:0]    core_out_ready;
  logic [3:0]    core_valid_out;
  logic [1023:0] core_out;
  logic          out_valid;
  logic          out_ready;
  logic [255:0]  out_hash;
  logic [31:0]   out_seq;
  logic [2:0]    in_flight;
  logic          err_stray;

  int vectors = 0;
  int errors  = 0;

  scrypt_multi_dispatch #(
    .WIDTH_IN  (640),
    .WIDTH_OUT (256),
    .NUM_CORES (4),
    .SEQ_W     (32)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_header      (in_header),
    .core_header    (core_header),
    .core_valid_in  (core_valid_in),
    .core_ready     (core_ready),
    .core_out_ready (core_out_ready),
    .core_valid_out (core_valid_out),
    .core_out       (core_out),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_hash       (out_hash),
    .out_seq        (out_seq),
    .in_flight      (in_flight),
    .err_stray      (err_stray)
  );

  always #5 clk = ~clk;

  function automatic logic [639:0] mk_hdr(input logic [31:0] s);
    return {20{s}};
  endfunction

  function automatic logic [255:0] mk_hash(input logic [31:0] s);
    return {8{s}};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [639:0] obs, input logic [639:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic push(input logic [639:0] h);
    in_valid  = 1'b1;
    in_header = h;
    tick();
    in_valid  = 1'b0;
  endtask

  task automatic set_hash(input int k, input logic [255:0] h);
    core_out[k*256 +: 256] = h;
  endtask

  task automatic strobe(input logic [3:0] mask);
    core_valid_out = mask;
    tick();
    core_valid_out = '0;
  endtask

  task automatic do_reset;
    in_valid       = 1'b0;
    core_valid_out = '0;
    out_ready      = 1'b1;
    rst_n          = 1'b0;
    tick();
    rst_n          = 1'b1;
  endtask

  initial begin
    rst_n          = 1'b0;
    in_valid       = 1'b0;
    in_header      = '0;
    core_ready     = 4'hF;
    core_valid_out = '0;
    core_out       = '0;
    out_ready      = 1'b1;
    tick();
    tick();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_core_out_ready", core_out_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_flight", in_flight, 0);
    chk("rst_core_valid_in", core_valid_in, 0);
    chk("rst_err_stray", err_stray, 0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_core_out_ready", core_out_ready, 4'hF);
    chk("post_rst_in_ready", in_ready, 1);

    // Single job through core 0
    push(mk_hdr(32'h1111_0000));
    chk("t1_core_valid_in", core_valid_in, 4'b0001);
    chk("t1_core_header", core_header, mk_hdr(32'h1111_0000));
    chk("t1_in_flight", in_flight, 1);
    tick();
    chk("t1_start_pulse_len", core_valid_in, 0);
    set_hash(0, mk_hash(32'hA0A0_0000));
    strobe(4'b0001);
    chk("t1_capture_no_out", out_valid, 0);
    tick();
    chk("t1_out_valid", out_valid, 1);
    chk("t1_out_hash", out_hash, mk_hash(32'hA0A0_0000));
    chk("t1_out_seq", out_seq, 0);
    tick();
    chk("t1_out_drop", out_valid, 0);
    chk("t1_in_flight_end", in_flight, 0);

    // Out-of-order completion, in-order retire
    do_reset();
    for (int i = 0; i < 4; i++) begin
      push(mk_hdr(32'h100 + i));
      chk("t2_dispatch_onehot", core_valid_in, 4'b0001 << i);
    end
    chk("t2_in_flight_full", in_flight, 4);
    chk("t2_full_in_ready", in_ready, 0);
    for (int k = 0; k < 4; k++) set_hash(k, mk_hash(32'hB0 + k));
    strobe(4'b1000);
    chk("t2_wait_after_c3", out_valid, 0);
    strobe(4'b0010);
    chk("t2_wait_after_c1", out_valid, 0);
    strobe(4'b0001);
    chk("t2_wait_after_c0", out_valid, 0);
    strobe(4'b0100);
    for (int i = 0; i < 4; i++) begin
      chk("t2_out_valid", out_valid, 1);
      chk("t2_out_seq", out_seq, i);
      chk("t2_out_hash", out_hash, mk_hash(32'hB0 + i));
      chk("t2_in_flight", in_flight, 3 - i);
      tick();
    end
    chk("t2_drained", out_valid, 0);

    // Full back-pressure; fifth header waits for seq 0 to retire
    do_reset();
    for (int i = 0; i < 4; i++) push(mk_hdr(32'h200 + i));
    in_valid  = 1'b1;
    in_header = mk_hdr(32'h204);
    chk("t3_full_in_ready", in_ready, 0);
    tick();
    tick();
    chk("t3_no_dispatch", core_valid_in, 0);
    chk("t3_in_flight", in_flight, 4);
    for (int k = 0; k < 4; k++) set_hash(k, mk_hash(32'hC0 + k));
    strobe(4'b0001);
    chk("t3_captured_not_free", in_ready, 0);
    tick();
    chk("t3_retire0_valid", out_valid, 1);
    chk("t3_retire0_seq", out_seq, 0);
    chk("t3_freed_in_ready", in_ready, 1);
    chk("t3_in_flight_3", in_flight, 3);
    tick();
    in_valid = 1'b0;
    chk("t3_fifth_core0", core_valid_in, 4'b0001);
    chk("t3_fifth_header", core_header, mk_hdr(32'h204));
    chk("t3_in_flight_4", in_flight, 4);
    set_hash(0, mk_hash(32'hC4));
    strobe(4'b1111);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t3_out_seq", out_seq, 1 + i);
      chk("t3_out_hash", out_hash, mk_hash(32'hC1 + i));
    end

    // Output stall holds out_* stable
    do_reset();
    out_ready = 1'b0;
    push(mk_hdr(32'h300));
    push(mk_hdr(32'h301));
    set_hash(0, mk_hash(32'hD0));
    set_hash(1, mk_hash(32'hD1));
    strobe(4'b0011);
    tick();
    chk("t4_first_valid", out_valid, 1);
    chk("t4_first_seq", out_seq, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t4_stall_valid", out_valid, 1);
      chk("t4_stall_seq", out_seq, 0);
      chk("t4_stall_hash", out_hash, mk_hash(32'hD0));
      chk("t4_stall_in_flight", in_flight, 1);
    end
    out_ready = 1'b1;
    tick();
    chk("t4_second_seq", out_seq, 1);
    chk("t4_second_hash", out_hash, mk_hash(32'hD1));
    tick();
    chk("t4_drained", out_valid, 0);
    chk("t4_in_flight_end", in_flight, 0);

    // Stray strobe on idle core
    do_reset();
    set_hash(2, mk_hash(32'hDEAD));
    strobe(4'b0100);
    chk("t5_err_stray", err_stray, 1);
    chk("t5_no_out", out_valid, 0);
    tick();
    chk("t5_no_out_later", out_valid, 0);
    chk("t5_in_flight", in_flight, 0);
    push(mk_hdr(32'h400));
    set_hash(0, mk_hash(32'hE0));
    strobe(4'b0001);
    tick();
    chk("t5_job_valid", out_valid, 1);
    chk("t5_job_hash", out_hash, mk_hash(32'hE0));
    chk("t5_job_seq", out_seq, 0);
    chk("t5_err_sticky", err_stray, 1);

    // Reset mid-run discards in-flight and captured results
    do_reset();
    for (int i = 0; i < 3; i++) push(mk_hdr(32'h500 + i));
    set_hash(0, mk_hash(32'hF0));
    set_hash(1, mk_hash(32'hF1));
    strobe(4'b0011);
    rst_n = 1'b0;
    tick();
    chk("t6_rst_out_valid", out_valid, 0);
    chk("t6_rst_in_flight", in_flight, 0);
    chk("t6_rst_core_out_ready", core_out_ready, 0);
    chk("t6_rst_in_ready", in_ready, 0);
    chk("t6_rst_out_hash", out_hash, 0);
    chk("t6_rst_out_seq", out_seq, 0);
    chk("t6_rst_core_header", core_header, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("t6_no_stale", out_valid, 0);
    end
    push(mk_hdr(32'h600));
    chk("t6_restart_core0", core_valid_in, 4'b0001);
    set_hash(0, mk_hash(32'hF9));
    strobe(4'b0001);
    tick();
    chk("t6_restart_valid", out_valid, 1);
    chk("t6_restart_seq", out_seq, 0);
    chk("t6_restart_hash", out_hash, mk_hash(32'hF9));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
